// File: rtl/sched_sequencer_if.sv
// Host-side bundle of the schedule sequencer: control loading, run control,
// buffer toggles and status.
interface sched_sequencer_if #(
    parameter int NUM_BUFF   = 12,
    parameter int MAX_PERIOD = 64,
    parameter int ITER_W     = 16
);
    localparam int CW = 2 * NUM_BUFF;
    localparam int PW = $clog2(MAX_PERIOD + 1);

    logic [CW-1:0]       ctrl_in;
    logic                load_ctrl;
    logic                load_clr;
    logic [PW-1:0]       period;
    logic [ITER_W-1:0]   iter_count;
    logic                start_ctrl;
    logic                stop_ctrl;
    logic [NUM_BUFF-1:0] buff_wr_toggle;
    logic [NUM_BUFF-1:0] buff_rd_toggle;
    logic                busy;
    logic                iter_done;
    logic                run_done;
    logic                load_full;
    logic                start_err;
    logic                load_err;

    modport master (
        output ctrl_in, load_ctrl, load_clr, period, iter_count,
        output start_ctrl, stop_ctrl,
        input  buff_wr_toggle, buff_rd_toggle, busy, iter_done,
        input  run_done, load_full, start_err, load_err
    );

    modport slave (
        input  ctrl_in, load_ctrl, load_clr, period, iter_count,
        input  start_ctrl, stop_ctrl,
        output buff_wr_toggle, buff_rd_toggle, busy, iter_done,
        output run_done, load_full, start_err, load_err
    );
endinterface

// File: rtl/sched_sequencer.sv
// Schedule sequencer: loads a table of toggle words, then replays it one
// word per clock for a number of iterations or until a graceful stop.
module sched_sequencer #(
    parameter int NUM_BUFF   = 12,
    parameter int MAX_PERIOD = 64,
    parameter int ITER_W     = 16
) (
    input logic              clk,
    input logic              rst,
    sched_sequencer_if.slave bus
);
    localparam int CW = 2 * NUM_BUFF;
    localparam int AW = $clog2(MAX_PERIOD);
    localparam int PW = $clog2(MAX_PERIOD + 1);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       mem [MAX_PERIOD];
    logic [PW-1:0]       wr_ptr, per_q;
    logic [AW-1:0]       rd_addr;
    logic [ITER_W-1:0]   iter_q, remaining;
    logic [CW-1:0]       word;
    logic [NUM_BUFF-1:0] word_wr, word_rd;
    logic idle, full, req, start_ok, start_bad, wr_en, last, finish;

    always_comb begin
        idle      = (state == IDLE);
        full      = (wr_ptr == PW'(MAX_PERIOD));
        req       = idle && bus.start_ctrl && !bus.stop_ctrl;
        start_ok  = req && (bus.period != '0) && (bus.period <= wr_ptr);
        start_bad = req && ((bus.period == '0) || (bus.period > wr_ptr));
        wr_en     = idle && !bus.load_clr && bus.load_ctrl && !full;
        last      = (PW'(rd_addr) == per_q - PW'(1));
        // A stop only takes effect at the end of the iteration in flight
        finish    = !idle && last &&
                    ((state == STOPPING) ||
                     ((iter_q != '0) && (remaining == ITER_W'(1))));
        word      = mem[rd_addr];
        for (int i = 0; i < NUM_BUFF; i++) begin
            word_wr[i] = word[2*i];
            word_rd[i] = word[2*i+1];
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start_ok) state_nx = RUN;
            RUN:      if (finish) state_nx = IDLE;
                      else if (bus.stop_ctrl) state_nx = STOPPING;
            STOPPING: if (finish) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.ctrl_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr             <= '0;
            per_q              <= '0;
            iter_q             <= '0;
            remaining          <= '0;
            rd_addr            <= '0;
            bus.buff_wr_toggle <= '0;
            bus.buff_rd_toggle <= '0;
            bus.busy           <= 1'b0;
            bus.iter_done      <= 1'b0;
            bus.run_done       <= 1'b0;
            bus.load_full      <= 1'b0;
            bus.start_err      <= 1'b0;
            bus.load_err       <= 1'b0;
        end else begin
            if (idle && bus.load_clr) begin
                wr_ptr       <= '0;
                bus.load_err <= 1'b0;
            end else if (bus.load_ctrl) begin
                if (wr_en) wr_ptr       <= wr_ptr + PW'(1);
                else       bus.load_err <= 1'b1;
            end
            bus.load_full <= idle && bus.load_clr ? 1'b0
                           : (wr_en ? (wr_ptr == PW'(MAX_PERIOD - 1)) : full);
            bus.start_err <= start_bad;
            if (start_ok) begin
                per_q     <= bus.period;
                iter_q    <= bus.iter_count;
                remaining <= bus.iter_count;
                rd_addr   <= '0;
            end else if (!idle) begin
                rd_addr <= last ? '0 : rd_addr + AW'(1);
                if (last && (iter_q != '0) && (remaining != '0))
                    remaining <= remaining - ITER_W'(1);
            end
            bus.busy <= start_ok || !idle;
            if (!idle) begin
                bus.buff_wr_toggle <= word_wr;
                bus.buff_rd_toggle <= word_rd;
                bus.iter_done      <= last;
                bus.run_done       <= finish;
            end else begin
                bus.buff_wr_toggle <= '0;
                bus.buff_rd_toggle <= '0;
                bus.iter_done      <= 1'b0;
                bus.run_done       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sched_sequencer.sv
// Directed bench for sched_sequencer: load, replay, stop, errors,
// saturation, mid-run reset and period-1 runs.
module tb_sched_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    sched_sequencer_if bus ();

    sched_sequencer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [23:0] wa [4];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] pk(logic b, logic id, logic rn,
                                       logic [23:0] w);
        logic [11:0] wr, rd;
        for (int i = 0; i < 12; i++) begin
            wr[i] = w[2*i];
            rd[i] = w[2*i+1];
        end
        return {b, id, rn, wr, rd};
    endfunction

    function automatic logic [26:0] obs();
        return {bus.busy, bus.iter_done, bus.run_done,
                bus.buff_wr_toggle, bus.buff_rd_toggle};
    endfunction

    function automatic logic [2:0] flags();
        return {bus.load_full, bus.load_err, bus.start_err};
    endfunction

    task automatic expw(string tag, logic b, logic id, logic rn,
                        logic [23:0] w);
        chk(tag, 32'(obs()), 32'(pk(b, id, rn, w)));
    endtask

    task automatic load(logic [23:0] w);
        bus.ctrl_in   = w;
        bus.load_ctrl = 1'b1;
        cyc();
        bus.load_ctrl = 1'b0;
    endtask

    task automatic clr();
        bus.load_clr = 1'b1;
        cyc();
        bus.load_clr = 1'b0;
    endtask

    task automatic start(int per, int it);
        bus.period     = 7'(per);
        bus.iter_count = 16'(it);
        bus.start_ctrl = 1'b1;
        cyc();
        bus.start_ctrl = 1'b0;
    endtask

    initial begin
        wa[0] = 24'h000003;
        wa[1] = 24'h800001;
        wa[2] = 24'h555555;
        wa[3] = 24'haaaaaa;
        bus.ctrl_in    = '0;
        bus.load_ctrl  = 1'b0;
        bus.load_clr   = 1'b0;
        bus.period     = '0;
        bus.iter_count = '0;
        bus.start_ctrl = 1'b0;
        bus.stop_ctrl  = 1'b0;
        cyc();
        cyc();
        chk("rst_out", 32'(obs()), 32'd0);
        chk("rst_flags", 32'(flags()), 32'd0);
        rst = 1'b1;
        cyc();

        // 1: two iterations of A,B,C,D
        for (int i = 0; i < 4; i++) load(wa[i]);
        start(4, 2);
        expw("t1_e0", 1'b1, 1'b0, 1'b0, 24'h0);
        for (int j = 0; j < 8; j++) begin
            cyc();
            expw("t1_word", 1'b1, j % 4 == 3, j == 7, wa[j%4]);
        end
        cyc();
        expw("t1_end", 1'b0, 1'b0, 1'b0, 24'h0);

        // 2: rejected starts
        clr();
        for (int i = 0; i < 3; i++) load(wa[i]);
        start(5, 2);
        chk("t2_err_big", 32'({bus.start_err, bus.busy}), 32'b10);
        cyc();
        chk("t2_err_pulse", 32'({bus.start_err, bus.busy}), 32'b00);
        start(0, 2);
        chk("t2_err_zero", 32'({bus.start_err, bus.busy}), 32'b10);
        bus.stop_ctrl = 1'b1;
        start(3, 2);
        bus.stop_ctrl = 1'b0;
        chk("t2_start_stop", 32'({bus.start_err, bus.busy}), 32'b00);
        cyc();

        // 3: endless run, stop lands on word 1 of iteration 3
        start(3, 0);
        for (int j = 0; j < 7; j++) begin
            cyc();
            expw("t3_word", 1'b1, j % 3 == 2, 1'b0, wa[j%3]);
        end
        bus.stop_ctrl = 1'b1;
        cyc();
        bus.stop_ctrl = 1'b0;
        expw("t3_stop_w1", 1'b1, 1'b0, 1'b0, wa[1]);
        cyc();
        expw("t3_last", 1'b1, 1'b1, 1'b1, wa[2]);
        cyc();
        expw("t3_end", 1'b0, 1'b0, 1'b0, 24'h0);

        // 6: period 1, three iterations, load attempted mid-run
        clr();
        load(wa[1]);
        start(1, 3);
        cyc();
        expw("t6_w0", 1'b1, 1'b1, 1'b0, wa[1]);
        bus.load_ctrl = 1'b1;
        cyc();
        bus.load_ctrl = 1'b0;
        expw("t6_w1", 1'b1, 1'b1, 1'b0, wa[1]);
        chk("t6_load_err", 32'(bus.load_err), 32'd1);
        cyc();
        expw("t6_w2", 1'b1, 1'b1, 1'b1, wa[1]);
        cyc();
        expw("t6_end", 1'b0, 1'b0, 1'b0, 24'h0);

        // 4: fill to depth, overflow, full-depth replay, clear
        clr();
        chk("t4_clr_err", 32'(flags()), 32'd0);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = 8'(i);
            load({b, 8'hc3, b});
        end
        chk("t4_full", 32'(flags()), 32'b100);
        load(24'hffffff);
        load(24'hffffff);
        chk("t4_over", 32'(flags()), 32'b110);
        start(64, 1);
        for (int j = 0; j < 64; j++) begin
            logic [7:0] b;
            b = 8'(j);
            cyc();
            expw("t4_word", 1'b1, j == 63, j == 63, {b, 8'hc3, b});
        end
        cyc();
        expw("t4_end", 1'b0, 1'b0, 1'b0, 24'h0);
        clr();
        chk("t4_clr", 32'(flags()), 32'd0);
        start(1, 1);
        chk("t4_empty_start", 32'(flags()), 32'b001);

        // 5: reset mid-run clears outputs and the table pointer
        clr();
        for (int i = 0; i < 4; i++) load(wa[i]);
        start(4, 0);
        cyc();
        cyc();
        expw("t5_run", 1'b1, 1'b0, 1'b0, wa[1]);
        #3 rst = 1'b0;
        #1;
        expw("t5_async", 1'b0, 1'b0, 1'b0, 24'h0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("t5_flags", 32'(flags()), 32'd0);
        start(4, 1);
        chk("t5_ptr_reset", 32'(flags()), 32'b001);
        for (int i = 0; i < 4; i++) load(wa[i]);
        start(4, 1);
        for (int j = 0; j < 4; j++) begin
            cyc();
            expw("t5_replay", 1'b1, j == 3, j == 3, wa[j]);
        end
        cyc();
        expw("t5_end", 1'b0, 1'b0, 1'b0, 24'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
